// File: rtl/waveform_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : waveform_analyzer
// Brief    : Rising-midscale-crossing detector (with hysteresis) that measures
//            period, min, max and peak-to-peak of each full sample cycle.
// Revision : 1.0
// ============================================================================
module waveform_analyzer #(
    parameter int PERIOD_W = 16,
    parameter int OFFSET   = 127,
    parameter int HYST     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sampleValid,
    input  logic [7:0]          sampleIn,
    input  logic                clear,
    output logic                measValid,
    output logic [PERIOD_W-1:0] period,
    output logic [7:0]          minVal,
    output logic [7:0]          maxVal,
    output logic [7:0]          peakToPeak,
    output logic                timeout
);

    localparam logic [7:0]          c_tl  = 8'(OFFSET - HYST);
    localparam logic [7:0]          c_th  = 8'(OFFSET + HYST);
    localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

    typedef enum logic [1:0] {
        SEEK_LOW  = 2'd0,
        SEEK_HIGH = 2'd1,
        MEAS_LOW  = 2'd2,
        MEAS_HIGH = 2'd3
    } state_t;

    state_t              r_state;
    logic [PERIOD_W-1:0] r_count;
    logic [7:0]          r_min;
    logic [7:0]          r_max;

    logic       w_low;
    logic       w_high;
    logic       w_cnt_sat;
    logic [7:0] w_min_upd;
    logic [7:0] w_max_upd;

    assign w_low     = (sampleIn <= c_tl);
    assign w_high    = (sampleIn >= c_th);
    assign w_cnt_sat = &r_count;
    assign w_min_upd = (sampleIn < r_min) ? sampleIn : r_min;
    assign w_max_upd = (sampleIn > r_max) ? sampleIn : r_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SEEK_LOW;
            r_count    <= '0;
            r_min      <= '0;
            r_max      <= '0;
            measValid  <= 1'b0;
            period     <= '0;
            minVal     <= '0;
            maxVal     <= '0;
            peakToPeak <= '0;
            timeout    <= 1'b0;
        end else if (clear) begin
            r_state    <= SEEK_LOW;
            r_count    <= '0;
            r_min      <= '0;
            r_max      <= '0;
            measValid  <= 1'b0;
            period     <= '0;
            minVal     <= '0;
            maxVal     <= '0;
            peakToPeak <= '0;
            timeout    <= 1'b0;
        end else begin
            measValid <= 1'b0;
            if (sampleValid) begin
                case (r_state)
                    SEEK_LOW: begin
                        if (w_low) r_state <= SEEK_HIGH;
                    end
                    SEEK_HIGH: begin
                        if (w_high) begin
                            r_count <= c_one;
                            r_min   <= sampleIn;
                            r_max   <= sampleIn;
                            r_state <= MEAS_LOW;
                        end
                    end
                    MEAS_LOW: begin
                        if (w_cnt_sat) begin
                            timeout <= 1'b1;
                            r_count <= '0;
                            r_state <= SEEK_LOW;
                        end else begin
                            r_count <= r_count + c_one;
                            r_min   <= w_min_upd;
                            r_max   <= w_max_upd;
                            if (w_low) r_state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        // The edge sample closes the old cycle and opens the next one.
                        if (w_high) begin
                            measValid  <= 1'b1;
                            period     <= r_count;
                            minVal     <= r_min;
                            maxVal     <= r_max;
                            peakToPeak <= r_max - r_min;
                            r_count    <= c_one;
                            r_min      <= sampleIn;
                            r_max      <= sampleIn;
                            r_state    <= MEAS_LOW;
                        end else if (w_cnt_sat) begin
                            timeout <= 1'b1;
                            r_count <= '0;
                            r_state <= SEEK_LOW;
                        end else begin
                            r_count <= r_count + c_one;
                            r_min   <= w_min_upd;
                            r_max   <= w_max_upd;
                        end
                    end
                    default: r_state <= SEEK_LOW;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/waveform_analyzer.md
Name: waveform_analyzer

Overview:
- Receive-side counterpart to the waveform generator: consumes the 8-bit offset-binary sample stream (midscale 127) produced for the DAC, e.g. looped back or from the ADC capture path.
- Detects rising midscale crossings with hysteresis and measures each full cycle: period in samples, minimum, maximum, peak-to-peak.
- Results are registered and flagged with a one-cycle valid pulse for the display/host logic.

Parameters:
- PERIOD_W, 16: width of the period counter and period output.
- OFFSET, 127: midscale level of the sample stream.
- HYST, 4: hysteresis half-band. Low threshold TL = OFFSET-HYST; high threshold TH = OFFSET+HYST. Legal range: HYST ≥ 1, TL ≥ 0, TH ≤ 255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- sampleValid  in  1  sampleIn is accepted on a rising clk edge when 1
- sampleIn  in  8  unsigned sample
- clear  in  1  synchronous; same effect as reset except it takes effect on the clock edge
- measValid  out  1  one-cycle pulse; result outputs are updated in the same cycle
- period  out  PERIOD_W  samples per cycle of the last measurement
- minVal  out  8  minimum sample in the last measured cycle
- maxVal  out  8  maximum sample in the last measured cycle
- peakToPeak  out  8  maxVal-minVal of the last measured cycle
- timeout  out  1  sticky flag: period counter saturated

Behaviour:
- Reset (rst=0) or clear=1:
  - state=SEEK_LOW; counter=0; internal min/max = 0.
  - All outputs 0 (measValid, period, minVal, maxVal, peakToPeak, timeout).
  - Reset mid-measurement discards the partial cycle; no pulse is emitted.
- Only accepted samples (sampleValid=1) advance state or counters. Idle cycles are ignored entirely and do not count.
- Comparisons are unsigned: low means sample ≤ TL; high means sample ≥ TH. Samples strictly between TL and TH never change state.
- FSM:
  - SEEK_LOW: a low sample moves to SEEK_HIGH.
  - SEEK_HIGH: a high sample is the first rising edge. Set counter=1, min=max=sample, go to MEAS_LOW.
  - MEAS_LOW: counter+1; update min/max; a low sample moves to MEAS_HIGH.
  - MEAS_HIGH, non-high sample: counter+1; update min/max.
  - MEAS_HIGH, high sample (rising edge):
    - Next cycle: measValid=1, period=counter (pre-increment value), minVal/maxVal = tracked values excluding the edge sample, peakToPeak = maxVal-minVal.
    - Then counter=1, min=max=edge sample; go to MEAS_LOW.
    - Latency: measValid rises on the cycle after the edge sample is accepted, for exactly 1 cycle.
- A measured cycle spans from an edge sample up to, but not including, the next edge sample.
- Outputs hold their last values between pulses.
- Saturation: if counter = all-ones and another non-edge sample is accepted in MEAS_LOW/MEAS_HIGH:
  - timeout=1 (sticky until rst/clear); state goes to SEEK_LOW; no measValid.
  - The edge sample at count all-ones is still a valid measurement.
- Simultaneous clear and sampleValid: clear wins and the sample is dropped.
- Consecutive edges are impossible without an intervening low sample, so the minimum reportable period is 2.
- peakToPeak is always non-negative; 8-bit, no wrap.

Test Plan:
- Square, 4×0 then 4×255 repeated, sampleValid=1 → first pulse after the 2nd rising edge; period=8, minVal=0, maxVal=255, peakToPeak=255; every 8 cycles thereafter.
- Same stream with sampleValid toggling 1/0 → period still 8 and pulses every 16 clk. Results identical.
- Triangle 100→160→100 step 10 (period 12 samples) → period=12, minVal=100, maxVal=160, peakToPeak=60.
- Noise 125,130,124,129 repeated after arming → no measValid; state stays put.
- PERIOD_W=4: edge, then constant 100 for 20 samples → timeout=1 when the 16th sample is accepted; no pulse; clear → timeout=0.
- rst=0 mid-MEAS_HIGH, then a fresh square wave → all outputs 0 during reset; first pulse only after two new rising edges. Repeat with clear asserted together with sampleValid → sample dropped.
